// File: rtl/instr_decode_queue.sv
// Instruction queue between fetch and register-read. LEGv8 format and operand
// fields are decoded as each entry is written, so the head entry is presented fully decoded.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_fmt,
  output logic [10:0]              out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rn,
  output logic [4:0]               out_rm,
  output logic [5:0]               out_shamt,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_D  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_CB = 3'd4;
  localparam logic [2:0] FMT_IW = 3'd5;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } dec_t;

  // Format checks run in priority order; the first match wins.
  function automatic dec_t decode_fields(input logic [31:0] instr);
    dec_t d;
    d.fmt = FMT_R;
    d.imm = '0;
    if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      d.fmt = FMT_B;
      d.imm = {{(XLEN-26){instr[25]}}, instr[25:0]};
    end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101 ||
                 instr[31:24] == 8'b01010100) begin
      d.fmt = FMT_CB;
      d.imm = {{(XLEN-19){instr[23]}}, instr[23:5]};
    end else if (instr[31:23] == 9'b110100101 || instr[31:23] == 9'b111100101) begin
      d.fmt = FMT_IW;
      d.imm = {{(XLEN-16){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1011000100 ||
                 instr[31:22] == 10'b1101000100 || instr[31:22] == 10'b1111000100 ||
                 instr[31:22] == 10'b1001001000 || instr[31:22] == 10'b1111001000 ||
                 instr[31:22] == 10'b1011001000 || instr[31:22] == 10'b1101001000) begin
      d.fmt = FMT_I;
      d.imm = {{(XLEN-12){1'b0}}, instr[21:10]};
    end else if (instr[29:23] == 7'b1110000 && !instr[21]) begin
      d.fmt = FMT_D;
      d.imm = {{(XLEN-9){instr[20]}}, instr[20:12]};
    end
    return d;
  endfunction

  logic [31:0]     instr_q [DEPTH];
  logic [2:0]      fmt_q   [DEPTH];
  logic [XLEN-1:0] imm_q   [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  dec_t          dec_in;

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dec_in    = decode_fields(in_instr);
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_q[wr_ptr_q] <= in_instr;
      fmt_q[wr_ptr_q]   <= dec_in.fmt;
      imm_q[wr_ptr_q]   <= dec_in.imm;
      pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_comb begin
    out_fmt    = '0;
    out_opcode = '0;
    out_rd     = '0;
    out_rn     = '0;
    out_rm     = '0;
    out_shamt  = '0;
    out_imm    = '0;
    out_pc     = '0;
    if (out_valid) begin
      out_fmt    = fmt_q[rd_ptr_q];
      out_opcode = instr_q[rd_ptr_q][31:21];
      out_rd     = instr_q[rd_ptr_q][4:0];
      out_rn     = instr_q[rd_ptr_q][9:5];
      out_rm     = instr_q[rd_ptr_q][20:16];
      out_shamt  = instr_q[rd_ptr_q][15:10];
      out_imm    = imm_q[rd_ptr_q];
      out_pc     = pc_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: table of decode vectors plus
// hand-written fill/drain, flush and asynchronous-reset sequences.
module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_fmt;
  logic [10:0] out_opcode;
  logic [4:0]  out_rd, out_rn, out_rm;
  logic [5:0]  out_shamt;
  logic [63:0] out_imm, out_pc;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;

  instr_decode_queue #(.DEPTH(4), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fmt(out_fmt), .out_opcode(out_opcode), .out_rd(out_rd), .out_rn(out_rn),
    .out_rm(out_rm), .out_shamt(out_shamt), .out_imm(out_imm), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [10:0] op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [5:0]  sh;
    logic [63:0] imm;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_gated(input string tag);
    check({tag, "_fmt"},   64'(out_fmt),    64'd0);
    check({tag, "_op"},    64'(out_opcode), 64'd0);
    check({tag, "_rd"},    64'(out_rd),     64'd0);
    check({tag, "_rn"},    64'(out_rn),     64'd0);
    check({tag, "_rm"},    64'(out_rm),     64'd0);
    check({tag, "_shamt"}, 64'(out_shamt),  64'd0);
    check({tag, "_imm"},   out_imm,         64'd0);
    check({tag, "_pc"},    out_pc,          64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            instr          pc       fmt  op      rd     rn     rm     sh     imm
    vecs[0]  = '{32'hD3400C22, 64'h100, 3'd0, 11'h69A, 5'd2,  5'd1,  5'd0,  6'd3,  64'h0};
    vecs[1]  = '{32'h91001441, 64'h104, 3'd1, 11'h488, 5'd1,  5'd2,  5'd0,  6'd5,  64'h5};
    vecs[2]  = '{32'hF85F8083, 64'h108, 3'd2, 11'h7C2, 5'd3,  5'd4,  5'd31, 6'd32, 64'hFFFFFFFFFFFFFFF8};
    vecs[3]  = '{32'h17FFFFFF, 64'h10C, 3'd3, 11'h0BF, 5'd31, 5'd31, 5'd31, 6'd63, 64'hFFFFFFFFFFFFFFFF};
    vecs[4]  = '{32'hF2D7DDE5, 64'h110, 3'd5, 11'h796, 5'd5,  5'd15, 5'd23, 6'd55, 64'h0000BEEF00000000};
    vecs[5]  = '{32'hB4000041, 64'h114, 3'd4, 11'h5A0, 5'd1,  5'd2,  5'd0,  6'd0,  64'h2};
    vecs[6]  = '{32'h54FFFFE0, 64'h118, 3'd4, 11'h2A7, 5'd0,  5'd31, 5'd31, 6'd63, 64'hFFFFFFFFFFFFFFFF};
    vecs[7]  = '{32'h94000010, 64'h11C, 3'd3, 11'h4A0, 5'd16, 5'd0,  5'd0,  6'd0,  64'h10};
    vecs[8]  = '{32'hD2E00020, 64'h120, 3'd5, 11'h697, 5'd0,  5'd1,  5'd0,  6'd0,  64'h0001000000000000};
    vecs[9]  = '{32'hB13FFC00, 64'h124, 3'd1, 11'h589, 5'd0,  5'd0,  5'd31, 6'd63, 64'hFFF};
    vecs[10] = '{32'hF8600000, 64'h128, 3'd0, 11'h7C3, 5'd0,  5'd0,  5'd0,  6'd0,  64'h0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check_gated("rst");
    rst_n = 1'b1;
    tick();

    // Decode table: push each word into an empty queue, inspect head, pop.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      check($sformatf("v%0d_no_bypass", i), 64'(out_valid), 64'd0);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 64'(out_valid),  64'd1);
      check($sformatf("v%0d_count", i), 64'(count),      64'd1);
      check($sformatf("v%0d_fmt", i),   64'(out_fmt),    64'(vecs[i].fmt));
      check($sformatf("v%0d_op", i),    64'(out_opcode), 64'(vecs[i].op));
      check($sformatf("v%0d_rd", i),    64'(out_rd),     64'(vecs[i].rd));
      check($sformatf("v%0d_rn", i),    64'(out_rn),     64'(vecs[i].rn));
      check($sformatf("v%0d_rm", i),    64'(out_rm),     64'(vecs[i].rm));
      check($sformatf("v%0d_shamt", i), 64'(out_shamt),  64'(vecs[i].sh));
      check($sformatf("v%0d_imm", i),   out_imm,         vecs[i].imm);
      check($sformatf("v%0d_pc", i),    out_pc,          vecs[i].pc);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_popped", i), 64'(count), 64'd0);
    end

    // Fill with out_ready low; the fifth push must stall.
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_instr = 32'h8B000000 | 32'(k);
      in_pc    = 64'h200 + 64'(4 * k);
      tick();
      check($sformatf("fill%0d_count", k), 64'(count), (k < 4) ? 64'(k + 1) : 64'd4);
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_rd",  64'(out_rd),   64'd0);
    out_ready = 1'b1;
    tick();
    check("drain0_count", 64'(count),    64'd3);
    check("drain0_rd",    64'(out_rd),   64'd1);
    check("drain0_ready", 64'(in_ready), 64'd1);
    tick();
    check("pushpop_count", 64'(count),  64'd3);
    check("pushpop_rd",    64'(out_rd), 64'd2);
    in_valid = 1'b0;
    tick();
    check("drain2_rd", 64'(out_rd), 64'd3);
    tick();
    check("drain3_rd",    64'(out_rd), 64'd4);
    check("drain3_pc",    out_pc,      64'h210);
    check("drain3_count", 64'(count),  64'd1);
    tick();
    out_ready = 1'b0;
    check("drained_valid", 64'(out_valid), 64'd0);

    // Flush with a same-cycle push discards everything.
    push1(32'h17FFFFFF, 64'h300);
    push1(32'hF2D7DDE5, 64'h304);
    push1(32'hF85F8083, 64'h308);
    check("preflush_count", 64'(count), 64'd3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h91001441;
    in_pc = 64'h30C;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_count",    64'(count),     64'd0);
    check("flush_valid",    64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready),  64'd1);
    check_gated("flush");

    // Asynchronous reset between clock edges.
    push1(32'hD3400C22, 64'h400);
    push1(32'h91001441, 64'h404);
    check("prereset_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count),     64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    push1(32'h91001441, 64'h500);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_fmt",   64'(out_fmt),   64'd1);
    check("post_rst_imm",   out_imm,        64'd5);
    check("post_rst_pc",    out_pc,         64'h500);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
